// File: rtl/seq_arith_pkg.sv
// Shared types for seq_arith_unit: opcode and FSM state encodings, iteration counter sizing.
package seq_arith_pkg;

  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_SQRT = 2'b01,
    OP_MUL  = 2'b10,
    OP_REM  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COMPUTE,
    ST_SIGN,
    ST_DONE
  } state_e;

  localparam int unsigned DEF_WORD_LENGHT = 8;

  // Counter must hold the full iteration count W, not just W-1.
  function automatic int unsigned iter_cnt_w(input int unsigned w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/seq_arith_unit_magnitude_to_a2.sv
// Combinational sign-magnitude to two's-complement conversion; a zero magnitude never yields a negative result.
module magnitude_to_a2 #(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] mag_i,
  input  logic             sign_i,
  output logic [WIDTH-1:0] a2_o
);

  always_comb begin
    a2_o = mag_i;
    if (sign_i && (mag_i != '0)) begin
      a2_o = ~mag_i + {{(WIDTH-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/seq_arith_unit.sv
// Multi-cycle shift/subtract MUL/DIV/REM/SQRT on sign-magnitude operands, two's-complement result.
// Optional SEQ_ARITH_EARLY_EXIT_EN: MUL leaves COMPUTE once the remaining multiplier bits are zero.
module seq_arith_unit
  import seq_arith_pkg::*;
#(
  parameter int unsigned WORD_LENGHT = DEF_WORD_LENGHT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WORD_LENGHT-1:0]   operand_1,
  input  logic                     sign_1,
  input  logic [WORD_LENGHT-1:0]   operand_2,
  input  logic                     sign_2,
  input  logic [1:0]               opCode,
  input  logic                     start,
  input  logic                     error_in,
  output logic [2*WORD_LENGHT-1:0] result,
  output logic                     busy,
  output logic                     ready,
  output logic                     error_out
);

  localparam int unsigned W  = WORD_LENGHT;
  localparam int unsigned W2 = 2 * W;
  localparam int unsigned HW = W / 2;
  localparam int unsigned SR = HW + 3;
  localparam int unsigned CW = iter_cnt_w(W);

  state_e          state_q, state_d;
  op_e             op_q, op_d;
  logic            sgn1_q, sgn1_d, sgn2_q, sgn2_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W2-1:0]   a_q, a_d;
  logic [W2-1:0]   b_q, b_d;
  logic [W-1:0]    c_q, c_d;
  logic [W2-1:0]   res_q, res_d;
  logic            err_q, err_d;

  op_e             op_in;
  logic            bad_in;
  logic            last_iter;
  logic [W:0]      div_r, div_t;
  logic [SR-1:0]   sq_r, sq_t;
  logic [SR:0]     sq_diff;
  logic [W2-1:0]   mag;
  logic            mag_sign;
  logic [W2-1:0]   a2_res;

  assign op_in  = op_e'(opCode);
  assign bad_in = error_in
                || (((op_in == OP_DIV) || (op_in == OP_REM)) && (operand_2 == '0))
                || ((op_in == OP_SQRT) && sign_1);

`ifdef SEQ_ARITH_EARLY_EXIT_EN
  assign last_iter = (cnt_q == CW'(1)) || ((op_q == OP_MUL) && (c_q[W-1:1] == '0));
`else
  assign last_iter = (cnt_q == CW'(1));
`endif

  // a_q: product / partial remainder; b_q: shifted multiplicand, dividend or radicand; c_q: multiplier, divisor or root
  always_comb begin
    div_r   = {a_q[W-1:0], b_q[W-1]};
    div_t   = div_r - {1'b0, c_q};
    sq_r    = {a_q[HW:0], b_q[W-1 -: 2]};
    sq_t    = {1'b0, c_q[HW-1:0], 2'b01};
    sq_diff = {1'b0, sq_r} - {1'b0, sq_t};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      op_q    <= OP_DIV;
      sgn1_q  <= 1'b0;
      sgn2_q  <= 1'b0;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      sgn1_q  <= sgn1_d;
      sgn2_q  <= sgn2_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      res_q   <= res_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (bad_in) begin
            state_d = ST_DONE;
`ifdef SEQ_ARITH_EARLY_EXIT_EN
          end else if ((op_in == OP_MUL) && (operand_2 == '0)) begin
            state_d = ST_SIGN;
`endif
          end else begin
            state_d = ST_COMPUTE;
          end
        end
      end
      ST_COMPUTE: if (last_iter) state_d = ST_SIGN;
      ST_SIGN:    state_d = ST_DONE;
      ST_DONE:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    op_d   = op_q;
    sgn1_d = sgn1_q;
    sgn2_d = sgn2_q;
    cnt_d  = cnt_q;
    a_d    = a_q;
    b_d    = b_q;
    c_d    = c_q;
    res_d  = res_q;
    err_d  = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          op_d   = op_in;
          sgn1_d = sign_1;
          sgn2_d = sign_2;
          a_d    = '0;
          b_d    = {{W{1'b0}}, operand_1};
          c_d    = (op_in == OP_SQRT) ? '0 : operand_2;
          cnt_d  = (op_in == OP_SQRT) ? CW'(HW) : CW'(W);
          if (bad_in) begin
            res_d = '0;
            err_d = 1'b1;
          end
        end
      end
      ST_COMPUTE: begin
        cnt_d = cnt_q - CW'(1);
        unique case (op_q)
          OP_MUL: begin
            a_d = a_q + (c_q[0] ? b_q : '0);
            b_d = b_q << 1;
            c_d = c_q >> 1;
          end
          OP_SQRT: begin
            b_d = b_q << 2;
            if (!sq_diff[SR]) begin
              a_d = W2'(sq_diff[SR-1:0]);
              c_d = {c_q[W-2:0], 1'b1};
            end else begin
              a_d = W2'(sq_r);
              c_d = {c_q[W-2:0], 1'b0};
            end
          end
          default: begin
            if (!div_t[W]) begin
              a_d = W2'(div_t[W-1:0]);
              b_d = {b_q[W2-2:0], 1'b1};
            end else begin
              a_d = W2'(div_r[W-1:0]);
              b_d = {b_q[W2-2:0], 1'b0};
            end
          end
        endcase
      end
      ST_SIGN: begin
        res_d = a2_res;
        err_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_comb begin
    mag      = '0;
    mag_sign = 1'b0;
    unique case (op_q)
      OP_MUL: begin
        mag      = a_q;
        mag_sign = sgn1_q ^ sgn2_q;
      end
      OP_DIV: begin
        mag      = {{W{1'b0}}, b_q[W-1:0]};
        mag_sign = sgn1_q ^ sgn2_q;
      end
      OP_REM: begin
        mag      = {{W{1'b0}}, a_q[W-1:0]};
        mag_sign = sgn1_q;
      end
      default: mag = {{(W2-HW){1'b0}}, c_q[HW-1:0]};
    endcase
  end

  magnitude_to_a2 #(
    .WIDTH (W2)
  ) u_mag_to_a2 (
    .mag_i  (mag),
    .sign_i (mag_sign),
    .a2_o   (a2_res)
  );

  always_comb begin
    busy      = (state_q == ST_COMPUTE) || (state_q == ST_SIGN);
    ready     = (state_q == ST_DONE);
    result    = res_q;
    error_out = err_q;
  end

endmodule

// File: tb/tb_seq_arith_unit.sv
// Directed + random bench for seq_arith_unit (W=8) with a result/latency scoreboard.
module tb_seq_arith_unit;

  logic        clk;
  logic        rst;
  logic [7:0]  operand_1, operand_2;
  logic        sign_1, sign_2;
  logic [1:0]  opCode;
  logic        start;
  logic        error_in;
  logic [15:0] result;
  logic        busy, ready, error_out;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [15:0] res;
    logic        err;
    int          lat;
  } exp_t;

  exp_t sb[$];

  seq_arith_unit #(.WORD_LENGHT(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .operand_1 (operand_1),
    .sign_1    (sign_1),
    .operand_2 (operand_2),
    .sign_2    (sign_2),
    .opCode    (opCode),
    .start     (start),
    .error_in  (error_in),
    .result    (result),
    .busy      (busy),
    .ready     (ready),
    .error_out (error_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_lat(input logic [1:0] op, input logic [7:0] o2, input logic is_err);
    if (is_err) return 1;
    if (op == 2'b01) return 6;
`ifdef SEQ_ARITH_EARLY_EXIT_EN
    if (op == 2'b10) begin
      if (o2 == 8'd0) return 2;
      for (int i = 7; i >= 0; i--) if (o2[i]) return i + 3;
    end
`endif
    return 10;
  endfunction

  function automatic logic [16:0] model(input logic [7:0] o1, input logic s1, input logic [7:0] o2,
                                        input logic s2, input logic [1:0] op, input logic ein);
    int unsigned m;
    logic        sg;
    logic [15:0] r;
    if (ein || (((op == 2'b00) || (op == 2'b11)) && (o2 == 8'd0)) || ((op == 2'b01) && s1))
      return {1'b1, 16'h0000};
    m  = 0;
    sg = 1'b0;
    case (op)
      2'b00: begin m = o1 / o2; sg = s1 ^ s2; end
      2'b01: begin for (int i = 0; i < 16; i++) if (i * i <= int'(o1)) m = i; end
      2'b10: begin m = o1 * o2; sg = s1 ^ s2; end
      default: begin m = o1 % o2; sg = s1; end
    endcase
    r = m[15:0];
    if (sg) r = -r;
    return {1'b0, r};
  endfunction

  task automatic run_op(input string tag, input logic [7:0] o1, input logic s1, input logic [7:0] o2,
                        input logic s2, input logic [1:0] op, input logic ein,
                        input logic [15:0] eres, input logic eerr, input int restart_at);
    exp_t e;
    int   cyc;
    e.res = eres;
    e.err = eerr;
    e.lat = exp_lat(op, o2, eerr);
    sb.push_back(e);
    operand_1 = o1; sign_1 = s1; operand_2 = o2; sign_2 = s2;
    opCode = op; error_in = ein; start = 1'b1;
    tick();
    cyc = 1;
    start = 1'b0;
    while (!ready && cyc < 40) begin
      chk({tag, "_busy"}, 32'(busy), 32'd1);
      operand_1 = 8'($urandom); operand_2 = 8'($urandom);
      sign_1 = 1'($urandom); sign_2 = 1'($urandom);
      opCode = 2'($urandom); error_in = 1'($urandom);
      start = (cyc == restart_at);
      tick();
      cyc++;
    end
    start = 1'b0;
    e = sb.pop_front();
    chk({tag, "_ready"},   32'(ready),     32'd1);
    chk({tag, "_latency"}, 32'(cyc),       32'(e.lat));
    chk({tag, "_result"},  32'(result),    32'(e.res));
    chk({tag, "_err"},     32'(error_out), 32'(e.err));
    chk({tag, "_busy_end"},32'(busy),      32'd0);
    tick();
    chk({tag, "_pulse"},   32'(ready),     32'd0);
    chk({tag, "_held"},    32'(result),    32'(e.res));
  endtask

  initial begin
    logic [16:0] m;
    logic [7:0]  r1, r2;
    logic        rs1, rs2, rein;
    logic [1:0]  rop;
    logic        saw;

    rst = 1'b0; start = 1'b0; error_in = 1'b0;
    operand_1 = '0; operand_2 = '0; sign_1 = 1'b0; sign_2 = 1'b0; opCode = 2'b00;
    #12;
    chk("rst_result", 32'(result),    32'd0);
    chk("rst_busy",   32'(busy),      32'd0);
    chk("rst_ready",  32'(ready),     32'd0);
    chk("rst_err",    32'(error_out), 32'd0);
    rst = 1'b1;
    tick();

    run_op("mul",       8'd12,  1'b0, 8'd5, 1'b1, 2'b10, 1'b0, 16'hFFC4, 1'b0, 0);
    run_op("div",       8'd100, 1'b1, 8'd7, 1'b0, 2'b00, 1'b0, 16'hFFF2, 1'b0, 0);
    run_op("rem",       8'd100, 1'b1, 8'd7, 1'b0, 2'b11, 1'b0, 16'hFFFE, 1'b0, 0);
    run_op("sqrt200",   8'd200, 1'b0, 8'd3, 1'b1, 2'b01, 1'b0, 16'h000E, 1'b0, 0);
    run_op("sqrt255",   8'd255, 1'b0, 8'd0, 1'b0, 2'b01, 1'b0, 16'h000F, 1'b0, 0);
    run_op("err_div0",  8'd50,  1'b0, 8'd0, 1'b0, 2'b00, 1'b0, 16'h0000, 1'b1, 0);
    run_op("err_in",    8'd12,  1'b0, 8'd5, 1'b0, 2'b10, 1'b1, 16'h0000, 1'b1, 0);
    run_op("err_sqrt",  8'd16,  1'b1, 8'd0, 1'b0, 2'b01, 1'b0, 16'h0000, 1'b1, 0);
    run_op("zero_sign", 8'd0,   1'b0, 8'd5, 1'b1, 2'b10, 1'b0, 16'h0000, 1'b0, 0);
    run_op("restart",   8'd12,  1'b0, 8'd5, 1'b1, 2'b10, 1'b0, 16'hFFC4, 1'b0, 4);
    run_op("mul_9x3",   8'd9,   1'b0, 8'd3, 1'b0, 2'b10, 1'b0, 16'h001B, 1'b0, 0);
    run_op("mul_x0",    8'd77,  1'b1, 8'd0, 1'b0, 2'b10, 1'b0, 16'h0000, 1'b0, 0);
    run_op("mul_max",   8'd255, 1'b1, 8'd255, 1'b0, 2'b10, 1'b0, 16'h01FF, 1'b0, 0);
    run_op("div_one",   8'd255, 1'b1, 8'd1, 1'b1, 2'b00, 1'b0, 16'h00FF, 1'b0, 0);
    run_op("mul_27",    8'd9,   1'b0, 8'd3, 1'b0, 2'b10, 1'b0, 16'h001B, 1'b0, 0);

    // Abort a MUL at cycle 5 with reset; no completion may follow.
    operand_1 = 8'd12; sign_1 = 1'b0; operand_2 = 8'd5; sign_2 = 1'b1;
    opCode = 2'b10; error_in = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    rst = 1'b0;
    #1;
    chk("abort_result", 32'(result),    32'd0);
    chk("abort_busy",   32'(busy),      32'd0);
    chk("abort_ready",  32'(ready),     32'd0);
    chk("abort_err",    32'(error_out), 32'd0);
    saw = 1'b0;
    repeat (2) begin tick(); if (ready) saw = 1'b1; end
    rst = 1'b1;
    repeat (12) begin tick(); if (ready || busy) saw = 1'b1; end
    chk("abort_no_ready", 32'(saw), 32'd0);

    run_op("post_rst", 8'd100, 1'b1, 8'd7, 1'b0, 2'b00, 1'b0, 16'hFFF2, 1'b0, 0);

    for (int k = 0; k < 8; k++) begin
      r1 = 8'($urandom); r2 = 8'($urandom);
      rs1 = 1'($urandom); rs2 = 1'($urandom);
      rop = 2'($urandom);
      rein = ($urandom_range(0, 7) == 0);
      if (k == 3) r2 = 8'd0;
      m = model(r1, rs1, r2, rs2, rop, rein);
      run_op($sformatf("rnd%0d", k), r1, rs1, r2, rs2, rop, rein, m[15:0], m[16], 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
